uart_rx_os: RTL

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_os_if.sv | 33 +++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_os.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the oversampling UART receiver.
// Parity modes, receiver FSM states and the 2-of-3 vote helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: received-word handshake bundle (ready/valid plus status).
// master = receiver side, slave = consumer side.
interface uart_rx_os_if #(
    parameter int DW = 8
);
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic          brk;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        output brk,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        input  brk,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider, one tick every DIV clocks.
// clr_i restarts the count so the first tick lands DIV clocks later.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST) & ~clr_i;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with ready/valid word hold.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each bit centre.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int      C_CLKFREQ    = 100_000_000,
    parameter int      C_BAUDRATE   = 625_000,
    parameter int      C_OVERSAMPLE = 16,
    parameter int      C_DATABITS   = 8,
    parameter parity_e C_PARITY     = PAR_NONE,
    parameter int      C_STOPBITS   = 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  rx_i,
    input  logic                  rx_ready_i,
    output logic [C_DATABITS-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  break_o
);

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    localparam int DIV = C_CLKFREQ / (C_BAUDRATE * C_OVERSAMPLE);
    // With voting the decision is taken one tick after the centre.
    localparam logic [4:0] T_HALF  = 5'(C_OVERSAMPLE / 2 + MAJ);
    localparam logic [4:0] T_FULL  = 5'(C_OVERSAMPLE + MAJ);
    localparam logic [4:0] T_RST   = 5'(MAJ);
    localparam logic [3:0] DB_LAST = 4'(C_DATABITS - 1);
    localparam logic [3:0] SB_LAST = 4'(C_STOPBITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_os: clock too slow for baud rate and oversampling");
    end
    if (C_OVERSAMPLE != 8 && C_OVERSAMPLE != 16) begin : g_bad_os
        $error("uart_rx_os: C_OVERSAMPLE must be 8 or 16");
    end
    if (C_DATABITS < 5 || C_DATABITS > 9) begin : g_bad_db
        $error("uart_rx_os: C_DATABITS must be 5..9");
    end
    if (C_STOPBITS != 1 && C_STOPBITS != 2) begin : g_bad_sb
        $error("uart_rx_os: C_STOPBITS must be 1 or 2");
    end

    rx_state_t             state_q, state_d;
    logic [1:0]            sync_q;
    logic                  prev_q;
    logic                  rx_s;
    logic                  tick;
    logic                  clr;
    logic                  strobe;
    logic                  bit_v;
    logic                  done;
    logic                  load;
    logic [4:0]            tcnt_q, tcnt_d;
    logic [4:0]            tgt;
    logic [3:0]            bcnt_q, bcnt_d;
    logic [C_DATABITS-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  zero_q, zero_d;
    logic [C_DATABITS-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  pe_q, pe_d;
    logic                  fe_q, fe_d;
    logic                  ovr_q, ovr_d;
    logic                  brk_q, brk_d;

    assign rx_s = sync_q[1];

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (clr),
        .tick_o (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] win_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            win_q <= 2'b11;
        end else if (tick) begin
            win_q <= {win_q[0], rx_s};
        end
    end

    assign bit_v = maj3({win_q, rx_s});
`else
    assign bit_v = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        zero_d  = zero_q;
        clr     = 1'b0;
        done    = 1'b0;
        strobe  = 1'b0;
        tgt     = (state_q == S_START) ? T_HALF : T_FULL;

        if (tick && state_q != S_IDLE && state_q != S_WAIT_IDLE) begin
            if (tcnt_q + 5'd1 == tgt) begin
                strobe = 1'b1;
                tcnt_d = T_RST;
            end else begin
                tcnt_d = tcnt_q + 5'd1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (prev_q && !rx_s) begin
                    clr     = 1'b1;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    zero_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (strobe) begin
                    state_d = bit_v ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (strobe) begin
                    shreg_d = {bit_v, shreg_q[C_DATABITS-1:1]};
                    par_d   = par_q ^ bit_v;
                    zero_d  = zero_q & ~bit_v;
                    bcnt_d  = bcnt_q + 4'd1;
                    if (bcnt_q == DB_LAST) begin
                        bcnt_d  = '0;
                        state_d = (C_PARITY == PAR_NONE) ? S_STOP : S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (strobe) begin
                    perr_d  = (C_PARITY == PAR_ODD) ? ~(par_q ^ bit_v)
                                                    : (par_q ^ bit_v);
                    zero_d  = zero_q & ~bit_v;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (strobe) begin
                    ferr_d = ferr_q | ~bit_v;
                    zero_d = zero_q & ~bit_v;
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q == SB_LAST) begin
                        done    = 1'b1;
                        bcnt_d  = '0;
                        state_d = ferr_d ? S_WAIT_IDLE : S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A completed frame is dropped only while an unconsumed word is held.
    always_comb begin
        load    = done & (~valid_q | rx_ready_i);
        data_d  = load ? shreg_q : data_q;
        pe_d    = load ? perr_q : pe_q;
        fe_d    = load ? ferr_d : fe_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
        ovr_d = done & ~load;
        brk_d = done & zero_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            zero_q  <= zero_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign parity_err_o = pe_q;
    assign frame_err_o  = fe_q;
    assign overrun_o    = ovr_q;
    assign break_o      = brk_q;

endmodule
